// File: rtl/rf_dump_if.sv
// rf_dump_if: register-file read port plus the outgoing byte stream of the
// register-file dump engine, bundled so the engine and its neighbours share
// one connection point.
interface rf_dump_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rf_addr;
  logic [31:0]       rf_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // Engine side: drives the RF address and the byte stream.
  modport master (
    output rf_addr, tx_data, tx_valid,
    input  rf_data, tx_ready
  );

  // RF / byte-sink side.
  modport slave (
    input  rf_addr, tx_data, tx_valid,
    output rf_data, tx_ready
  );
endinterface

// File: rtl/rf_dump.sv
// rf_dump: walks registers 0..NREGS-1 through the RF asynchronous read port,
// snapshots each word and streams it big-endian as bytes over a valid/ready
// channel.  Optional macro RF_DUMP_INDEX_EN prefixes each word with a byte
// holding the register index (5 bytes per register instead of 4).
module rf_dump #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  rf_dump_if.master  bus,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef RF_DUMP_INDEX_EN
  localparam logic [2:0] LAST_B = 3'd4;
`else
  localparam logic [2:0] LAST_B = 3'd3;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [2:0]        bcnt;
  logic [31:0]       word;
  logic [7:0]        tx_byte;

  // Select the byte at position b of the frame for register i.
  function automatic logic [7:0] frame_byte(input logic [31:0] w,
                                            input logic [ADDR_W-1:0] i,
                                            input logic [2:0] b);
    logic [7:0] r;
    r = 8'h00;
`ifdef RF_DUMP_INDEX_EN
    case (b)
      3'd0:    r = 8'(i);
      3'd1:    r = w[31:24];
      3'd2:    r = w[23:16];
      3'd3:    r = w[15:8];
      3'd4:    r = w[7:0];
      default: r = 8'h00;
    endcase
`else
    case (b)
      3'd0:    r = w[31:24];
      3'd1:    r = w[23:16];
      3'd2:    r = w[15:8];
      3'd3:    r = w[7:0];
      default: r = 8'h00;
    endcase
    if (i != i) r = 8'h00;  // index unused in this build; keeps the signature uniform
`endif
    return r;
  endfunction

  // Control FSM: idle -> (load -> send bytes) per register -> done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= '0;
      bcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            idx   <= '0;
            bcnt  <= '0;
          end
        end
        S_LOAD: state <= S_SEND;
        S_SEND: begin
          if (bus.tx_ready) begin
            if (bcnt == LAST_B) begin
              bcnt <= '0;
              if (idx == LAST_IDX) begin
                state <= S_DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= S_LOAD;
              end
            end else begin
              bcnt <= bcnt + 3'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Word snapshot taken at the end of LOAD; isolates the stream from later RF writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else if (state == S_LOAD) begin
      word <= bus.rf_data;
    end
  end

  // Current byte, forced to zero outside SEND so the idle bus is quiet.
  always_comb begin
    tx_byte = 8'h00;
    if (state == S_SEND) tx_byte = frame_byte(word, idx, bcnt);
  end

  assign bus.rf_addr  = idx;
  assign bus.tx_data  = tx_byte;
  assign bus.tx_valid = (state == S_SEND);
  assign busy         = (state == S_LOAD) || (state == S_SEND);
  assign done         = (state == S_DONE);

endmodule
